// File: rtl/dual_queue_pkg.sv
// Shared constants and pointer helper for the dual FIFO queue block.
package dual_queue_pkg;

  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned Q0_WORDS_DEF = 16;
  localparam int unsigned Q1_WORDS_DEF = 24;

  // Depth need not be a power of two, so wrap is an explicit compare.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned words);
    return (ptr == words - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/dual_queue_fifo_queue.sv
// One circular FIFO answering to a single select value; output is zero
// unless selected and non-empty.
module fifo_queue
  import dual_queue_pkg::*;
#(
  parameter logic        ADDR  = 1'b0,
  parameter int unsigned WORDS = Q0_WORDS_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic             empty,
  output logic             full,
  input  logic             queue_select,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CW = $clog2(WORDS + 1);

  logic [WIDTH-1:0] mem_q [WORDS];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sel, do_push, do_pop;

  assign sel   = (queue_select == ADDR);
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(WORDS));

  // A pop frees a slot the same edge, so push+pop on a full queue is legal;
  // pop on empty is dropped even when a push accompanies it.
  assign do_pop  = sel && pop && !empty;
  assign do_push = sel && push && (!full || do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_pop)  head_d = AW'(ptr_inc(32'(head_q), WORDS));
    if (do_push) tail_d = AW'(ptr_inc(32'(tail_q), WORDS));
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[tail_q] <= data_in;
  end

  assign data_out = (sel && !empty) ? mem_q[head_q] : '0;

endmodule

// File: rtl/dual_queue.sv
// Two independent FIFOs behind a shared push/pop/select port; the
// unselected queue drives zero so the outputs simply OR together.
module dual_queue
  import dual_queue_pkg::*;
#(
  parameter int unsigned Q0_WORDS = Q0_WORDS_DEF,
  parameter int unsigned Q1_WORDS = Q1_WORDS_DEF,
  parameter int unsigned WIDTH    = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic             q0_empty,
  output logic             q0_full,
  output logic             q1_empty,
  output logic             q1_full,
  input  logic             queue_select,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] q0_out, q1_out;

  fifo_queue #(.ADDR(1'b0), .WORDS(Q0_WORDS), .WIDTH(WIDTH)) u_q0 (
    .clk          (clk),
    .rst          (rst),
    .empty        (q0_empty),
    .full         (q0_full),
    .queue_select (queue_select),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (q0_out)
  );

  fifo_queue #(.ADDR(1'b1), .WORDS(Q1_WORDS), .WIDTH(WIDTH)) u_q1 (
    .clk          (clk),
    .rst          (rst),
    .empty        (q1_empty),
    .full         (q1_full),
    .queue_select (queue_select),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (q1_out)
  );

  assign data_out = q0_out | q1_out;

endmodule

// File: tb/tb_dual_queue.sv
// Directed plus random stimulus against a queue-based reference model.
module tb_dual_queue;

  localparam int D0 = 16;
  localparam int D1 = 24;

  logic       clk = 1'b0;
  logic       rst, queue_select, push, pop;
  logic [7:0] data_in, data_out;
  logic       q0_empty, q0_full, q1_empty, q1_full;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m0[$];
  logic [7:0] m1[$];

  dual_queue dut (
    .clk          (clk),
    .rst          (rst),
    .q0_empty     (q0_empty),
    .q0_full      (q0_full),
    .q1_empty     (q1_empty),
    .q1_full      (q1_full),
    .queue_select (queue_select),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    logic [7:0] exp_do;
    if (queue_select) exp_do = (m1.size() > 0) ? m1[0] : 8'h00;
    else              exp_do = (m0.size() > 0) ? m0[0] : 8'h00;
    chk("q0_empty", 32'(q0_empty), 32'(m0.size() == 0));
    chk("q0_full",  32'(q0_full),  32'(m0.size() == D0));
    chk("q1_empty", 32'(q1_empty), 32'(m1.size() == 0));
    chk("q1_full",  32'(q1_full),  32'(m1.size() == D1));
    chk("data_out", 32'(data_out), 32'(exp_do));
  endtask

  // Apply one cycle of inputs, advance the model by the queue rules, check.
  task automatic step(input logic r, input logic s, input logic pu,
                      input logic po, input logic [7:0] d);
    int  sz, dep;
    bit  popok, pushok;
    rst = r; queue_select = s; push = pu; pop = po; data_in = d;
    @(posedge clk);
    if (r) begin
      m0.delete();
      m1.delete();
    end else begin
      sz     = s ? m1.size() : m0.size();
      dep    = s ? D1 : D0;
      popok  = po && sz > 0;
      pushok = pu && (sz < dep || popok);
      if (s) begin
        if (popok)  void'(m1.pop_front());
        if (pushok) m1.push_back(d);
      end else begin
        if (popok)  void'(m0.pop_front());
        if (pushok) m0.push_back(d);
      end
    end
    #1;
    chk_model();
  endtask

  initial begin
    rst = 1'b1; queue_select = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;

    // Reset state
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    chk("rst_q0_empty", 32'(q0_empty), 1);
    chk("rst_q1_empty", 32'(q1_empty), 1);
    chk("rst_dout", 32'(data_out), 0);

    // Ordering on queue 0
    step(0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 8'h22);
    step(0, 0, 1, 0, 8'h33);
    chk("ord_h0", 32'(data_out), 32'h11);
    step(0, 0, 0, 1, 8'h00);
    chk("ord_h1", 32'(data_out), 32'h22);
    step(0, 0, 0, 1, 8'h00);
    chk("ord_h2", 32'(data_out), 32'h33);
    step(0, 0, 0, 1, 8'h00);
    chk("ord_empty", 32'(q0_empty), 1);
    chk("ord_dout0", 32'(data_out), 0);

    // Fill / overflow / wrap on queue 1
    for (int i = 0; i < 24; i++) step(0, 1, 1, 0, 8'(i));
    chk("q1_fill_full", 32'(q1_full), 1);
    step(0, 1, 1, 0, 8'hFF);
    chk("q1_ovf_head", 32'(data_out), 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 8'hA0 + 8'(i));
    chk("q1_wrap_full", 32'(q1_full), 1);
    for (int i = 0; i < 24; i++) begin
      chk("q1_drain", 32'(data_out), (i < 19) ? 32'(i + 5) : 32'(8'hA0 + 8'(i - 19)));
      step(0, 1, 0, 1, 8'h00);
    end
    chk("q1_drained", 32'(q1_empty), 1);

    // Independence
    step(0, 0, 1, 0, 8'h5A);
    step(0, 1, 1, 0, 8'hC3);
    for (int i = 0; i < 4; i++) begin
      step(0, 1'(i), 0, 0, 8'h00);
      chk("indep_dout", 32'(data_out), (i % 2) ? 32'hC3 : 32'h5A);
      chk("indep_ne", 32'(q0_empty | q1_empty), 0);
    end
    step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 1, 8'h00);

    // Push+pop on empty, then on full
    step(0, 0, 1, 1, 8'h77);
    chk("pp_empty_dout", 32'(data_out), 32'h77);
    for (int i = 1; i < 16; i++) step(0, 0, 1, 0, 8'h40 + 8'(i));
    chk("pp_full_pre", 32'(q0_full), 1);
    step(0, 0, 1, 1, 8'h99);
    chk("pp_full_stays", 32'(q0_full), 1);
    chk("pp_full_head", 32'(data_out), 32'h41);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 8'h00);
    chk("pp_last", 32'(data_out), 32'h99);
    step(0, 0, 0, 1, 8'h00);

    // Pop on empty
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 3; i++) begin
        step(0, 1'(s), 0, 1, 8'h00);
        chk("pope_dout", 32'(data_out), 0);
        chk("pope_empty", 32'(q0_empty & q1_empty), 1);
      end

    // Mid-stream reset
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 8'($urandom));
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'($urandom));
    step(1, 0, 1, 0, 8'hEE);
    chk("mrst_empty", 32'(q0_empty & q1_empty), 1);
    chk("mrst_dout", 32'(data_out), 0);
    step(0, 0, 0, 0, 8'h00);
    chk("mrst_discard", 32'(data_out), 0);

    // Random traffic with push-biased and pop-biased phases
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 300) % 2) ? 30 : 70;
      step(($urandom_range(0, 499) == 0), 1'($urandom),
           ($urandom_range(0, 99) < bias), ($urandom_range(0, 99) >= bias - 15),
           8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
